// File: rtl/pc_gen.sv
// pc_gen: fetch program-counter generator with a small circular return-address
// stack. Next PC priority: trap flush, EX redirect, RAS return, sequential.
module pc_gen #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     RAS_DEPTH    = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         en,
  input  logic                         flush_valid,
  input  logic [XLEN-1:0]              flush_target,
  input  logic                         redirect_valid,
  input  logic [XLEN-1:0]              redirect_target,
  input  logic                         call_push,
  input  logic [XLEN-1:0]              link_addr,
  input  logic                         ret_pop,
  output logic [XLEN-1:0]              pc,
  output logic [XLEN-1:0]              pc_plus4,
  output logic                         misaligned,
  output logic                         ras_empty,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ret_miss
);

  localparam int unsigned     PW   = $clog2(RAS_DEPTH);
  localparam int unsigned     CW   = PW + 1;
  localparam logic [XLEN-1:0] FOUR = XLEN'(4);
  localparam logic [CW-1:0]   FULL = CW'(RAS_DEPTH);

  logic [XLEN-1:0] pc_q, pc_n;
  logic [CW-1:0]   cnt_q, cnt_n;
  logic [PW-1:0]   tp_q, tp_n;
  logic            miss_q, miss_n;
  logic            wr_en;
  logic [PW-1:0]   wr_idx;
  logic [XLEN-1:0] ras_mem [RAS_DEPTH];

  logic qual, do_push, do_pop, empty;

  assign qual       = en & ~flush_valid & ~redirect_valid;
  assign do_push    = qual & call_push;
  assign do_pop     = qual & ret_pop;
  assign empty      = (cnt_q == '0);

  assign pc         = pc_q;
  assign pc_plus4   = pc_q + FOUR;
  assign misaligned = |pc_q[1:0];
  assign ras_empty  = empty;
  assign ras_count  = cnt_q;
  assign ret_miss   = miss_q;

  // Next-state selection for PC and RAS pointer/count.
  // tp_q indexes the current top; the stack wraps, so a push onto a full
  // stack silently overwrites the oldest entry.
  always_comb begin
    pc_n   = pc_q;
    cnt_n  = cnt_q;
    tp_n   = tp_q;
    miss_n = 1'b0;
    wr_en  = 1'b0;
    wr_idx = tp_q;
    if (flush_valid) begin
      pc_n  = flush_target;
      cnt_n = '0;
    end else if (redirect_valid) begin
      pc_n = redirect_target;
    end else if (do_pop && !empty) begin
      pc_n = ras_mem[tp_q];
      if (do_push) begin
        // Return and call together: consume top, replace it in place.
        wr_en  = 1'b1;
        wr_idx = tp_q;
      end else begin
        tp_n  = tp_q - PW'(1);
        cnt_n = cnt_q - CW'(1);
      end
    end else begin
      if (en)
        pc_n = pc_plus4;
      if (do_pop)
        miss_n = 1'b1;
      if (do_push) begin
        tp_n   = tp_q + PW'(1);
        wr_en  = 1'b1;
        wr_idx = tp_q + PW'(1);
        if (cnt_q != FULL)
          cnt_n = cnt_q + CW'(1);
      end
    end
  end

  // Control state registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q   <= RESET_VECTOR;
      cnt_q  <= '0;
      tp_q   <= '0;
      miss_q <= 1'b0;
    end else begin
      pc_q   <= pc_n;
      cnt_q  <= cnt_n;
      tp_q   <= tp_n;
      miss_q <= miss_n;
    end
  end

  // RAS entry storage; contents are don't-care while count is zero.
  always_ff @(posedge clk) begin
    if (reset_n && wr_en)
      ras_mem[wr_idx] <= link_addr;
  end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  - XLEN, 32, PC width in bits (legal: 32 or 64).
  - RESET_VECTOR, 0, PC value loaded on reset (XLEN bits).
  - RAS_DEPTH, 4, return-address-stack entries (legal: 2..16, power of two).
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  - clk, in, 1, single clock; all state on rising edge.
  - reset_n, in, 1, asynchronous active-low reset.
  - en, in, 1, PCWrite; 0 = stall/hold.
  - flush_valid, in, 1, trap/exception redirect request.
  - flush_target, in, XLEN, trap vector.
  - redirect_valid, in, 1, branch/jump resolution redirect from EX.
  - redirect_target, in, XLEN, resolved target.
  - call_push, in, 1, decode saw a call; push link_addr.
  - link_addr, in, XLEN, return address to push.
  - ret_pop, in, 1, decode saw a return; predict-redirect to RAS top and pop.
  - pc, out, XLEN, current fetch PC (registered).
  - pc_plus4, out, XLEN, pc + 4, combinational, wraps modulo 2^XLEN.
  - misaligned, out, 1, pc[1:0] != 0, combinational.
  - ras_empty, out, 1, RAS count == 0.
  - ras_count, out, clog2(RAS_DEPTH)+1, valid RAS entries.
  - ret_miss, out, 1, registered one-cycle pulse: qualified ret_pop seen with RAS empty.

Function
REQ-003 Next-PC selection SHALL use fixed priority, evaluated each rising edge: flush_valid > redirect_valid > qualified ret_pop > en > hold.
REQ-004 flush_valid=1 SHALL load pc <= flush_target regardless of en, and SHALL clear the RAS (count <= 0) in the same edge; call_push/ret_pop that cycle SHALL be ignored.
REQ-005 redirect_valid=1 with flush_valid=0 SHALL load pc <= redirect_target regardless of en; RAS contents and count SHALL be unchanged; call_push/ret_pop that cycle SHALL be ignored (decode instruction squashed).
REQ-006 Qualified push/pop SHALL mean en=1 and flush_valid=0 and redirect_valid=0; unqualified push/pop SHALL have no effect.
REQ-007 Qualified ret_pop with RAS non-empty SHALL load pc <= RAS top and decrement count by 1.
REQ-008 Qualified ret_pop with RAS empty SHALL leave count at 0, take the en path (pc <= pc+4) and pulse ret_miss for exactly one cycle.
REQ-009 No redirect source active and en=1 SHALL load pc <= pc+4, wrapping from 2^XLEN-4 to 0.
REQ-010 No redirect source active and en=0 SHALL hold pc unchanged.
REQ-011 Qualified call_push alone SHALL write link_addr as new top; count SHALL increment, saturating at RAS_DEPTH.
REQ-012 Push when count == RAS_DEPTH SHALL overwrite the oldest entry (circular buffer); count SHALL stay RAS_DEPTH.
REQ-013 Qualified call_push and ret_pop in the same cycle with RAS non-empty SHALL redirect pc to the old top, then replace top with link_addr; count SHALL be unchanged.
REQ-014 Qualified call_push and ret_pop in the same cycle with RAS empty SHALL push link_addr (count 0->1), take pc+4 and pulse ret_miss.
REQ-015 Redirect targets SHALL be loaded unmodified; misaligned SHALL assert combinationally while pc[1:0] != 0; no internal trap is raised.
REQ-016 All updates SHALL have one-cycle latency (request at edge N visible on pc after edge N).

Reset
REQ-017 reset_n=0 SHALL immediately (asynchronously) force pc=RESET_VECTOR, RAS count=0, ret_miss=0; RAS entry storage need not be cleared.
REQ-018 Reset asserted mid-operation (stall, pending redirect, full RAS) SHALL abort it; first post-reset edge with en=1 and no requests SHALL yield pc=RESET_VECTOR+4.

Verification
REQ-019 Bench SHALL cover, with XLEN=32, RESET_VECTOR=0, RAS_DEPTH=4:
  - Release reset, en=1 three cycles -> pc 0x0, 0x4, 0x8, 0xC.
  - en=0 with redirect_valid=1, target 0x100, same cycle flush_valid=1, target 0x80 -> pc=0x80, ras_count=0.
  - Push 0x10,0x20,0x30,0x40,0x50 (one per cycle), then ret_pop x4 -> pc 0x50,0x40,0x30,0x20; ras_count 4->0; 5th pop -> ret_miss pulse, pc+4.
  - ras_count=2, top 0x24, call_push link 0x60 and ret_pop together -> pc=0x24, count stays 2, next pop -> pc=0x60.
  - pc=0xFFFF_FFFC, en=1 -> pc=0x0; redirect target 0x102 -> pc=0x102, misaligned=1.
  - ras_count=3 and en=0, assert reset_n=0 mid-cycle -> pc=0x0, ras_empty=1 before next edge.
